// File: rtl/shiftreg_tx_pkg.sv
// Shared definitions for the serial transmitter and its matching receiver.
// Holds the frame state encoding and the bit-order constants.
package shiftreg_tx_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   localparam logic DIR_MSB_FIRST = 1'b0;
   localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/shiftreg_tx.sv
// Parallel-to-serial transmitter with valid/ready load, bit-rate enable,
// abort, selectable bit order and a done pulse after each full frame.
module shiftreg_tx
   import shiftreg_tx_pkg::*;
#(
   parameter int SIZE = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [SIZE-1:0] data_in,
   input  logic            load_valid,
   output logic            load_ready,
   input  logic            dir_in,
   input  logic            en,
   input  logic            abort,
   output logic            sd,
   output logic            sd_en,
   output logic            sd_dir,
   output logic            busy,
   output logic            done
);

   localparam int CW = $clog2(SIZE + 1);
   localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

   state_e          state_q, state_d;
   logic [SIZE-1:0] work_q, work_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            dir_q, dir_d;
   logic            done_q, done_d;

   // Output decode: sd comes from registers only, the strobe gates on en/abort.
   always_comb begin
      load_ready = (state_q == IDLE);
      busy       = (state_q == SHIFT);
      sd_en      = busy & en & ~abort;
      sd         = (dir_q == DIR_LSB_FIRST) ? work_q[0] : work_q[SIZE-1];
      sd_dir     = dir_q;
      done       = done_q;
   end

   // Next-state logic: load in IDLE, shift per strobe, abort wins over en.
   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_valid) begin
               state_d = SHIFT;
               work_d  = data_in;
               dir_d   = dir_in;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            if (abort) begin
               state_d = IDLE;
            end else if (en) begin
               if (dir_q == DIR_MSB_FIRST) begin
                  work_d = work_q << 1;
               end else begin
                  work_d = work_q >> 1;
               end
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         work_q  <= '0;
         cnt_q   <= '0;
         dir_q   <= DIR_MSB_FIRST;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_shiftreg_tx.sv
// Bench for shiftreg_tx: a frame-level model plus a loopback receiver,
// directed frames with literal expectations and a random phase.
module tb_shiftreg_tx;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] data_in;
   logic         load_valid;
   logic         load_ready;
   logic         dir_in;
   logic         en;
   logic         abort;
   logic         sd;
   logic         sd_en;
   logic         sd_dir;
   logic         busy;
   logic         done;

   shiftreg_tx #(.SIZE(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .dir_in     (dir_in),
      .en         (en),
      .abort      (abort),
      .sd         (sd),
      .sd_en      (sd_en),
      .sd_dir     (sd_dir),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;

   // Frame-level model: which word, which order, how many bits already sent.
   bit           m_busy = 0;
   logic [N-1:0] m_word = '0;
   bit           m_dir = 0;
   int           m_idx = 0;
   bit           m_done = 0;
   bit           chk_on = 0;

   logic [N-1:0] rx = '0;
   logic [N-1:0] cap = '0;
   int           strobes = 0;
   int           sl = 0;
   logic [N-1:0] last_cap = '0;
   int           last_done_at = 0;
   int           n_done = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   // Per-cycle compare against the model, then advance the model.
   always @(negedge clk) begin
      logic exp_sd;
      bit   acc;
      sl++;
      if (chk_on) begin
         chk("load_ready", load_ready, !m_busy);
         chk("busy", busy, m_busy);
         chk("sd_en", sd_en, m_busy && en && !abort);
         chk("sd_dir", sd_dir, m_dir);
         chk("done", done, m_done);
         if (m_busy) begin
            exp_sd = m_dir ? m_word[m_idx] : m_word[N-1-m_idx];
            chk("sd", sd, exp_sd);
         end
         if (m_done) chk("rx_word", rx, m_word);
      end
      if (sd_en === 1'b1) begin
         cap = {cap[N-2:0], sd};
         strobes++;
         rx = sd_dir ? {sd, rx[N-1:1]} : {rx[N-2:0], sd};
      end
      if (done === 1'b1) begin
         last_cap = cap;
         last_done_at = sl;
         n_done++;
      end
      acc = 0;
      if (rst) begin
         m_busy = 0;
         m_idx = 0;
         m_dir = 0;
         m_done = 0;
         chk_on = 1;
      end else begin
         m_done = 0;
         if (!m_busy) begin
            if (load_valid) begin
               m_busy = 1;
               m_word = data_in;
               m_dir = dir_in;
               m_idx = 0;
               acc = 1;
            end
         end else if (abort) begin
            m_busy = 0;
         end else if (en) begin
            m_idx++;
            if (m_idx == N) begin
               m_busy = 0;
               m_done = 1;
            end
         end
      end
      if (acc) begin
         sl = 0;
         cap = '0;
         strobes = 0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string nm);
      bit seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1;
         else step();
      end
      chk(nm, seen, 1);
      step();
   endtask

   task automatic frame(input logic [N-1:0] w, input logic d,
                        input bit toggle);
      bit seen = 0;
      load_valid = 1;
      data_in = w;
      dir_in = d;
      en = 1;
      abort = 0;
      step();
      load_valid = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
         en = toggle ? (k % 2 == 0) : 1'b1;
         if (toggle && k == 4) begin
            data_in = 8'hFF;
            dir_in = ~d;
            load_valid = 1;
         end
         if (toggle && k == 8) load_valid = 0;
         @(negedge clk);
         if (done === 1'b1) seen = 1;
         else step();
      end
      chk("frame_timeout", seen, 1);
      step();
   endtask

   initial begin
      int nd0;
      rst = 1;
      data_in = '0;
      load_valid = 0;
      dir_in = 0;
      en = 0;
      abort = 0;
      step();
      step();
      rst = 0;
      step();

      frame(8'hC1, 1'b0, 0);
      chk("msb_seq", last_cap, 8'hC1);
      chk("msb_done_cycle", last_done_at, 9);

      frame(8'hC1, 1'b1, 0);
      chk("lsb_seq", last_cap, 8'h83);

      frame(8'h5A, 1'b0, 1);
      chk("gap_strobes", strobes, 8);
      chk("gap_done_cycle", last_done_at, 16);
      chk("gap_seq", last_cap, 8'h5A);

      nd0 = n_done;
      load_valid = 1;
      data_in = 8'hF0;
      dir_in = 0;
      en = 1;
      step();
      load_valid = 0;
      step();
      step();
      step();
      abort = 1;
      step();
      abort = 0;
      @(negedge clk);
      chk("abort_ready", load_ready, 1);
      step();
      step();
      chk("abort_strobes", strobes, 3);
      chk("abort_no_done", n_done, nd0);
      frame(8'h0F, 1'b0, 0);
      chk("after_abort_seq", last_cap, 8'h0F);

      nd0 = n_done;
      load_valid = 1;
      data_in = 8'h11;
      dir_in = 0;
      en = 1;
      step();
      data_in = 8'h22;
      wait_done("b2b_first");
      load_valid = 0;
      wait_done("b2b_second");
      chk("b2b_count", n_done, nd0 + 2);
      chk("b2b_seq", last_cap, 8'h22);
      chk("b2b_done_cycle", last_done_at, 9);

      load_valid = 1;
      data_in = 8'h77;
      en = 1;
      step();
      load_valid = 0;
      step();
      step();
      step();
      step();
      rst = 1;
      step();
      rst = 0;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", load_ready, 1);
      step();
      frame(8'hA3, 1'b0, 0);
      chk("after_rst_seq", last_cap, 8'hA3);

      for (int i = 0; i < 500; i++) begin
         rst = ($urandom_range(99) == 0);
         load_valid = $urandom_range(1);
         data_in = N'($urandom);
         dir_in = $urandom_range(1);
         en = ($urandom_range(9) < 7);
         abort = ($urandom_range(29) == 0);
         step();
      end
      rst = 0;
      load_valid = 0;
      abort = 0;
      en = 1;
      repeat (20) step();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/shiftreg_tx.md
SHIFTREG_TX -- requirements
Module: shiftreg_tx

Interface
REQ-001 The block SHALL accept parameter SIZE, default 8, giving the word width in bits (minimum 2).
REQ-002 Port clk, input, 1: clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous, active-high.
REQ-004 Port data_in, input, SIZE: parallel word to transmit.
REQ-005 Port load_valid, input, 1: producer offers data_in and dir_in.
REQ-006 Port load_ready, output, 1: block accepts a word this cycle.
REQ-007 Port dir_in, input, 1: bit order; 0 = MSB first, 1 = LSB first.
REQ-008 Port en, input, 1: bit-rate enable; one bit is emitted per enabled cycle.
REQ-009 Port abort, input, 1: cancels the frame in progress.
REQ-010 Port sd, output, 1: serial data bit.
REQ-011 Port sd_en, output, 1: bit strobe; the receiver samples sd on the edge ending this cycle.
REQ-012 Port sd_dir, output, 1: latched bit order of the current frame, for the receiver's dir input.
REQ-013 Port busy, output, 1: frame in progress.
REQ-014 Port done, output, 1: one-cycle pulse after the last bit of a completed frame.

Function
REQ-015 The FSM SHALL have two states, IDLE and SHIFT; load_ready = (state == IDLE), busy = (state == SHIFT).
REQ-016 In IDLE with load_valid = 1, the block SHALL capture data_in into a SIZE-bit working register, capture dir_in into sd_dir, clear the bit counter, and enter SHIFT on that edge.
REQ-017 sd SHALL be combinational from registers only: working[SIZE-1] when sd_dir = 0, working[0] when sd_dir = 1.
REQ-018 sd_en SHALL equal busy & en & ~abort.
REQ-019 On each edge with sd_en = 1, the working register SHALL shift one place toward the sd end (zero fill), and the counter (width $clog2(SIZE+1)) SHALL increment.
REQ-020 On the edge where sd_en = 1 and the counter equals SIZE-1, the block SHALL return to IDLE and register done = 1 for exactly the next cycle.
REQ-021 Bit order SHALL be chosen so that a SIZE-bit serial-in receiver fed with d = sd, en = sd_en and dir = sd_dir holds data_in exactly when done is high.
REQ-022 Gaps in en SHALL stall the frame with no bit lost or repeated; sd SHALL stay stable while en = 0.
REQ-023 While in SHIFT, load_valid, data_in and dir_in SHALL be ignored.
REQ-024 abort = 1 in SHIFT SHALL return the block to IDLE on that edge, with no done pulse and no further sd_en; abort SHALL take priority over en. abort in IDLE SHALL be ignored.
REQ-025 A load SHALL be accepted in the cycle where done is high, giving back-to-back frames with a one-cycle gap in sd_en after the load.

Reset
REQ-026 rst SHALL override all other inputs and set state = IDLE, working = 0, counter = 0, sd_dir = 0 and done = 0; sd_en and busy SHALL therefore be 0 in the following cycle.
REQ-027 rst asserted mid-frame SHALL discard the frame with no done pulse.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE, SHIFT) and the bit-order constants DIR_MSB_FIRST = 0 and DIR_LSB_FIRST = 1, for use by both the transmitter and the receiver.
REQ-029 The design SHALL be a single module with no sub-modules; the counter and working register SHALL be inline.

Verification (SIZE = 8; bench loops the block back into the serial-in receiver)
REQ-030 Load 0xC1, dir_in = 0, en held at 1 -> sd sequence 1,1,0,0,0,0,0,1 in cycles 1-8; done high in cycle 9; receiver q = 0xC1.
REQ-031 Load 0xC1, dir_in = 1, en held at 1 -> sd sequence 1,0,0,0,0,0,1,1; receiver q = 0xC1 at done.
REQ-032 Load 0x5A with en toggling every cycle -> exactly 8 sd_en strobes over 16 cycles; receiver q = 0x5A; data_in changed to 0xFF mid-frame has no effect.
REQ-033 Load 0xF0 and assert abort after 3 strobes -> next cycle load_ready = 1, no done pulse, no further sd_en; a following load of 0x0F completes normally.
REQ-034 Hold load_valid = 1 with words 0x11 then 0x22 -> second word accepted in the done cycle of the first; both frames are received intact.
REQ-035 Assert rst after 4 bits -> next cycle busy = 0, done = 0, load_ready = 1; a subsequent load of 0xA3 transmits correctly.
